// File: rtl/register_universal.sv
// register_universal: WIDTH-bit register with synchronous clear, enable and a
// mode-selected operation (load, shift, rotate, increment, decrement).
// Provides a registered carry/shift-out flag and a combinational zero flag.
module register_universal #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    parameter bit                 SATURATE  = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_serial_in,
    output logic [WIDTH-1:0] out,
    output logic             o_carry,
    output logic             o_zero
);

    // Operation encodings for i_mode
    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_INC   = 3'b110,
        MODE_DEC   = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             carry_q;
    logic             carry_d;

    // Next-state selection: clear beats enable; disabled or hold mode keeps state
    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        if (i_clear) begin
            out_d   = ALL_ZERO;
            carry_d = 1'b0;
        end else if (i_enable) begin
            case (i_mode)
                MODE_HOLD: begin
                    out_d   = out_q;
                    carry_d = carry_q;
                end
                MODE_LOAD: begin
                    out_d   = i_data;
                    carry_d = 1'b0;
                end
                MODE_SHL: begin
                    out_d   = {out_q[WIDTH-2:0], i_serial_in};
                    carry_d = out_q[WIDTH-1];
                end
                MODE_SHR: begin
                    out_d   = {i_serial_in, out_q[WIDTH-1:1]};
                    carry_d = out_q[0];
                end
                MODE_ROL: begin
                    out_d   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                    carry_d = out_q[WIDTH-1];
                end
                MODE_ROR: begin
                    out_d   = {out_q[0], out_q[WIDTH-1:1]};
                    carry_d = out_q[0];
                end
                MODE_INC: begin
                    // All-ones either wraps to zero or sticks, carry flags the event
                    if (out_q == ALL_ONES) begin
                        out_d   = SATURATE ? ALL_ONES : ALL_ZERO;
                        carry_d = 1'b1;
                    end else begin
                        out_d   = out_q + ONE;
                        carry_d = 1'b0;
                    end
                end
                MODE_DEC: begin
                    // Zero either wraps to all-ones or sticks, carry flags the borrow
                    if (out_q == ALL_ZERO) begin
                        out_d   = SATURATE ? ALL_ZERO : ALL_ONES;
                        carry_d = 1'b1;
                    end else begin
                        out_d   = out_q - ONE;
                        carry_d = 1'b0;
                    end
                end
                default: begin
                    // Unknown mode: propagate X so the problem is visible downstream
                    out_d   = {WIDTH{1'bx}};
                    carry_d = 1'bx;
                end
            endcase
        end else begin
            out_d   = out_q;
            carry_d = carry_q;
        end
    end

    // State register with asynchronous reset to RESET_VAL
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q   <= RESET_VAL;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign out     = out_q;
    assign o_carry = carry_q;
    assign o_zero  = (out_q == ALL_ZERO);

endmodule
